// File: rtl/fft_pkg.sv
// Shared constants for the 64-point SDF FFT pipeline sequencer.
// Stage latencies and twiddle taps are derived at elaboration time.
package fft_pkg;

    localparam int NFFT   = 64;
    localparam int LOG2N  = 6;
    localparam int BF_LAT = 1;
    localparam int TW_LAT = 2;

    localparam logic [LOG2N-1:0] TW_MASK = 6'b001101;

    // Feedback delay of stage k (1-based).
    function automatic int stage_dly(input int k);
        return NFFT >> k;
    endfunction

    // Cycles from sample 0 accepted to sample 0 at stage-k input.
    function automatic int stage_lat(input int k);
        int l;
        l = 0;
        for (int j = 1; j < k; j++) begin
            l = l + stage_dly(j) + BF_LAT + (TW_MASK[j-1] ? TW_LAT : 0);
        end
        return l;
    endfunction

    // Token tap that starts the stage-k twiddle address generator.
    function automatic int tw_tap(input int k);
        return stage_lat(k) + stage_dly(k) + BF_LAT - 1;
    endfunction

    localparam int TOTAL_LAT = stage_lat(LOG2N + 1);

endpackage

// File: rtl/fft_token_delay.sv
// One-bit token shift line with synchronous clear.
// Tap i carries the input delayed by i cycles; tap 0 is the input itself.
module fft_token_delay #(
    parameter int LEN = 76
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           din_i,
    output logic [LEN-1:0] taps_o
);

    logic [LEN-1:1] line_q;

    // Shift frame-start tokens down the line, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else begin
            line_q <= {line_q[LEN-2:1], din_i};
        end
    end

    assign taps_o = {line_q, din_i};

endmodule

// File: rtl/sdf_fft_ctrl.sv
// Central sequencer for the 64-point SDF FFT pipeline.
// Counts samples, tracks frames and drives per-stage mode and twiddle starts.
module sdf_fft_ctrl
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LOG2N-1:0] bf_sel,
    output logic [LOG2N-1:0] tw_active,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_idx,
    output logic             busy,
    output logic             frame_err
);

    localparam int LEN = TOTAL_LAT + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(NFFT - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    logic [0:0]       state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic             open_q, open_d;
    logic             err_q, err_d;
    logic             ov_q, ov_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic [LOG2N-1:0] hold_q, hold_d;
    logic [LOG2N-1:0] bf_q, bf_d;
    logic [LEN-1:0]   taps;
    logic             start;
    logic             drained;

    assign in_ready = ~rst;
    assign start    = in_valid & ~rst
                    & ((state_q == S_IDLE) | (cnt_q == '0));

    fft_token_delay #(
        .LEN (LEN)
    ) u_tok (
        .clk_i  (clk),
        .rst_i  (rst),
        .din_i  (start),
        .taps_o (taps)
    );

    // Nothing left in flight once this cycle's tokens shift on.
    assign drained = ~|taps[LEN-1:1]
                   & ~(ov_q & (idx_q != LAST));

    for (genvar k = 0; k < LOG2N; k++) begin : g_stage
        localparam int LK = stage_lat(k + 1);
        localparam logic [LOG2N-1:0] OFS = LOG2N'(LK % NFFT);
        localparam logic [LOG2N-1:0] SEL = ONE << (LOG2N - 1 - k);

        logic [LOG2N-1:0] ph_now;
        logic [LOG2N-1:0] ph_nxt;

        assign ph_now    = cnt_q - OFS;
        assign ph_nxt    = cnt_d - OFS;
        assign hold_d[k] = (ph_now == LAST) ? 1'b0
                         : (hold_q[k] | taps[LK]);
        assign bf_d[k]   = hold_d[k] & (|(ph_nxt & SEL));

        if (TW_MASK[k]) begin : g_tw
            localparam int TAP = tw_tap(k + 1);
            assign tw_active[k] = taps[TAP];
        end else begin : g_no_tw
            assign tw_active[k] = 1'b0;
        end
    end

    // Sample counter, frame tracking and run/idle sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
        err_d   = err_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (start) begin
                state_d = S_RUN;
                cnt_d   = ONE;
            end
        end else begin
            cnt_d = cnt_q + ONE;
            if ((cnt_q == LAST) && !start && drained) begin
                state_d = S_IDLE;
            end
        end
        if (start) begin
            open_d = 1'b1;
        end else if (cnt_q == LAST) begin
            open_d = 1'b0;
        end
        if ((state_q == S_RUN) && (cnt_q != '0) && open_q && !in_valid) begin
            err_d = 1'b1;
        end
    end

    // Output window: opens one cycle after the last stage token tap.
    always_comb begin
        ov_d  = 1'b0;
        idx_d = '0;
        if (taps[TOTAL_LAT-1]) begin
            ov_d  = 1'b1;
            idx_d = '0;
        end else if (ov_q && (idx_q != LAST)) begin
            ov_d  = 1'b1;
            idx_d = idx_q + ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            open_q  <= 1'b0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            hold_q  <= '0;
            bf_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            bf_q    <= bf_d;
        end
    end

    assign bf_sel    = bf_q;
    assign out_valid = ov_q;
    assign out_idx   = idx_q;
    assign busy      = (state_q == S_RUN);
    assign frame_err = err_q;

endmodule

// File: tb/tb_sdf_fft_ctrl.sv
// Self-checking bench for sdf_fft_ctrl.
// Expected outputs come from frame start times and the latency formulas.
module tb_sdf_fft_ctrl;
    import fft_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] bf_sel;
    logic [5:0] tw_active;
    logic       out_valid;
    logic [5:0] out_idx;
    logic       busy;
    logic       frame_err;

    sdf_fft_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bf_sel    (bf_sel),
        .tw_active (tw_active),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [5:0] tw;
        logic       bf0;
        logic       ov;
        logic [5:0] idx;
        logic       bsy;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int base = 0;
    int ls = -100000;
    bit err_m = 1'b0;
    int starts[$];
    int lk [1:7];
    int dk [1:6];

    logic [5:0] log_tw  [0:399];
    logic [5:0] log_bf  [0:399];
    logic       log_ov  [0:399];
    logic [5:0] log_idx [0:399];
    logic       log_err [0:399];
    logic       log_bsy [0:399];

    vec_t tbl [15];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s t=%0d actual=%0d required=%0d",
                         nm, t, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_bf_sel", bf_sel, 0);
            chk("rst_tw", tw_active, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_idx", out_idx, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_err", frame_err, 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        starts.delete();
        err_m = 1'b0;
        ls = -100000;
    endtask

    task automatic cyc(input logic v, input bit first);
        logic [5:0] etw, ebf, eidx;
        logic       eov;
        int         a;
        in_valid = v;
        if (v && first) begin
            starts.push_back(t);
            ls = t;
        end
        @(negedge clk);
        etw = '0;
        ebf = '0;
        eov = 1'b0;
        eidx = '0;
        foreach (starts[i]) begin
            a = t - starts[i];
            for (int k = 1; k <= 6; k++) begin
                if (TW_MASK[k-1] && a == lk[k] + dk[k] + BF_LAT - 1)
                    etw[k-1] = 1'b1;
                if (a >= lk[k] && a < lk[k] + NFFT)
                    ebf[k-1] = 1'(((a - lk[k]) % NFFT) >> (6 - k));
            end
            if (a >= lk[7] && a < lk[7] + NFFT) begin
                eov = 1'b1;
                eidx = 6'(a - lk[7]);
            end
        end
        chk("in_ready", in_ready, 1);
        chk("tw_active", tw_active, etw);
        chk("bf_sel", bf_sel, ebf);
        chk("out_valid", out_valid, eov);
        chk("out_idx", out_idx, eidx);
        chk("frame_err", frame_err, err_m);
        a = t - ls;
        if (a >= 1 && a <= lk[7] + NFFT - 1)
            chk("busy_hi", busy, 1);
        else if (a >= 3 * NFFT)
            chk("busy_lo", busy, 0);
        if (!v) begin
            foreach (starts[i]) begin
                a = t - starts[i];
                if (a >= 1 && a < NFFT) err_m = 1'b1;
            end
        end
        a = t - base;
        if (a >= 0 && a < 400) begin
            log_tw[a]  = tw_active;
            log_bf[a]  = bf_sel;
            log_ov[a]  = out_valid;
            log_idx[a] = out_idx;
            log_err[a] = frame_err;
            log_bsy[a] = busy;
        end
        while (starts.size() > 0 && t - starts[0] > 300)
            void'(starts.pop_front());
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic frame(input int drop_at);
        for (int o = 0; o < NFFT; o++)
            cyc((o == drop_at) ? 1'b0 : 1'b1, o == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        lk[1] = 0;
        for (int k = 1; k <= 6; k++) begin
            dk[k] = NFFT >> k;
            lk[k+1] = lk[k] + dk[k] + BF_LAT + (TW_MASK[k-1] ? TW_LAT : 0);
        end

        tbl[0]  = '{0,   6'b000000, 1'b0, 1'b0, 6'd0,  1'b0};
        tbl[1]  = '{1,   6'b000000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[2]  = '{31,  6'b000000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[3]  = '{32,  6'b000001, 1'b1, 1'b0, 6'd0,  1'b1};
        tbl[4]  = '{59,  6'b000000, 1'b1, 1'b0, 6'd0,  1'b1};
        tbl[5]  = '{60,  6'b000100, 1'b1, 1'b0, 6'd0,  1'b1};
        tbl[6]  = '{63,  6'b000000, 1'b1, 1'b0, 6'd0,  1'b1};
        tbl[7]  = '{64,  6'b000000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[8]  = '{67,  6'b001000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[9]  = '{74,  6'b000000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[10] = '{75,  6'b000000, 1'b0, 1'b1, 6'd0,  1'b1};
        tbl[11] = '{100, 6'b000000, 1'b0, 1'b1, 6'd25, 1'b1};
        tbl[12] = '{138, 6'b000000, 1'b0, 1'b1, 6'd63, 1'b1};
        tbl[13] = '{139, 6'b000000, 1'b0, 1'b0, 6'd0,  1'b1};
        tbl[14] = '{200, 6'b000000, 1'b0, 1'b0, 6'd0,  1'b0};

        rst = 1'b1;
        in_valid = 1'b1;
        do_reset(3);

        base = t;
        frame(-1);
        idle(140);
        for (int i = 0; i < 15; i++) begin
            chk("tbl_tw", log_tw[tbl[i].c], tbl[i].tw);
            chk("tbl_bf0", log_bf[tbl[i].c][0], tbl[i].bf0);
            chk("tbl_ov", log_ov[tbl[i].c], tbl[i].ov);
            chk("tbl_idx", log_idx[tbl[i].c], tbl[i].idx);
            chk("tbl_busy", log_bsy[tbl[i].c], tbl[i].bsy);
        end

        do_reset(1);
        base = t;
        frame(-1);
        frame(-1);
        idle(200);
        chk("b2b_tw2_60", log_tw[60][2], 1);
        chk("b2b_tw2_124", log_tw[124][2], 1);
        chk("b2b_tw2_92", log_tw[92][2], 0);
        for (int c = 75; c <= 202; c++) chk("b2b_ov", log_ov[c], 1);
        chk("b2b_idx138", log_idx[138], 63);
        chk("b2b_idx139", log_idx[139], 0);
        chk("b2b_idx202", log_idx[202], 63);
        chk("b2b_ov203", log_ov[203], 0);

        do_reset(1);
        base = t;
        frame(-1);
        idle(64);
        frame(-1);
        idle(210);
        chk("gap_ov170", log_ov[170], 0);
        chk("gap_ov203", log_ov[203], 1);
        chk("gap_idx203", log_idx[203], 0);
        chk("gap_idx266", log_idx[266], 63);
        chk("gap_ov267", log_ov[267], 0);
        for (int c = 68; c <= 123; c++) chk("gap_tw", log_tw[c], 0);

        do_reset(1);
        base = t;
        frame(20);
        idle(250);
        chk("drop_err20", log_err[20], 0);
        chk("drop_err21", log_err[21], 1);
        chk("drop_err300", log_err[300], 1);
        chk("drop_tw32", log_tw[32], 1);
        chk("drop_tw67", log_tw[67], 8);
        chk("drop_ov75", log_ov[75], 1);
        chk("drop_ov139", log_ov[139], 0);

        do_reset(1);
        for (int o = 0; o < 40; o++) cyc(1'b1, o == 0);
        do_reset(2);
        idle(100);
        base = t;
        frame(-1);
        idle(200);
        chk("rst_tw32", log_tw[32], 1);
        chk("rst_ov75", log_ov[75], 1);
        chk("rst_idx138", log_idx[138], 63);

        do_reset(1);
        for (int s = 0; s < 16; s++) begin
            int ty;
            int d;
            ty = $urandom_range(0, 3);
            d = $urandom_range(1, 63);
            for (int o = 0; o < NFFT; o++)
                cyc((ty == 0 || (ty == 3 && o == d)) ? 1'b0 : 1'b1, o == 0);
        end
        idle(4 * NFFT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
